// File: rtl/npc_pkg.sv
// Shared types and helpers for the next-PC unit: selector/branch-type encodings and the
// branch-condition decode.
package npc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_JLBL = 2'd1,
        SEL_JREG = 2'd2,
        SEL_CALL = 2'd3
    } npc_sel_e;

    typedef enum logic [2:0] {
        BR_ALW  = 3'd0,
        BR_Z    = 3'd1,
        BR_NZ   = 3'd2,
        BR_C    = 3'd3,
        BR_NC   = 3'd4,
        BR_NMSB = 3'd5,
        BR_MSB  = 3'd6,
        BR_NEV  = 3'd7
    } npc_br_e;

    localparam int unsigned PC_INC = 4;

    function automatic logic br_taken(npc_br_e br, logic z, logic c, logic m);
        logic t;
        t = 1'b0;
        case (br)
            BR_ALW:  t = 1'b1;
            BR_Z:    t = z;
            BR_NZ:   t = ~z;
            BR_C:    t = c;
            BR_NC:   t = ~c;
            BR_NMSB: t = ~m;
            BR_MSB:  t = m;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/next_pc_unit_if.sv
// Decode/fetch-side bus of the next-PC unit. The unit itself uses the slave modport; the
// decode/fetch stage (or a testbench) uses master.
interface next_pc_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned OFF_W  = 16,
    parameter int unsigned JLBL_W = 26
) ();
    logic              stall;
    logic              ctl_valid;
    logic [1:0]        counter_selector;
    logic [2:0]        brtype;
    logic              ret;
    logic              zero_flag;
    logic              carry_flag;
    logic              msb;
    logic [OFF_W-1:0]  branch_label;
    logic [JLBL_W-1:0] jmp_label;
    logic [XLEN-1:0]   jmp_ra;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   link_addr;
    logic              flush;
    logic              ras_mispredict;
    logic              ras_empty;
    logic              ras_full;

    modport master (
        output stall, ctl_valid, counter_selector, brtype, ret, zero_flag, carry_flag, msb,
               branch_label, jmp_label, jmp_ra,
        input  pc, link_addr, flush, ras_mispredict, ras_empty, ras_full
    );

    modport slave (
        input  stall, ctl_valid, counter_selector, brtype, ret, zero_flag, carry_flag, msb,
               branch_label, jmp_label, jmp_ra,
        output pc, link_addr, flush, ras_mispredict, ras_empty, ras_full
    );
endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack. Pushing when full overwrites the oldest entry and keeps the
// count saturated; popping when empty is ignored. DEPTH must be a power of two.
module npc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [XLEN-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // wr_ptr always points one past the top; with the pointer wrapping, the slot written
    // when full is exactly the oldest entry.
    assign top_ptr  = wr_ptr_q - PTR_W'(1);
    assign top_data = mem_q[top_ptr];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_d = top_ptr;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter unit: owns the PC register and selects sequential/branch/jump/call targets.
// Define NPC_RAS_EN to build in the return-address stack; otherwise ret is ignored.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     OFF_W     = 16,
    parameter int unsigned     JLBL_W    = 26,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input logic           clk,
    input logic           rst_n,
    next_pc_unit_if.slave bus
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jlbl_target;
    logic [XLEN-1:0] nxt;
    logic            upd;
    logic            is_call;
    logic            is_ret;
    logic            ras_empty;
    logic            ras_full;

    assign upd      = ~bus.stall;
    assign pc_plus4 = pc_q + XLEN'(PC_INC);
    assign br_target = pc_plus4
        + ({{(XLEN - OFF_W){bus.branch_label[OFF_W-1]}}, bus.branch_label} << 2);
    assign jlbl_target = {pc_plus4[XLEN-1:JLBL_W+2], bus.jmp_label, 2'b00};

    assign is_call = upd && bus.ctl_valid && (npc_sel_e'(bus.counter_selector) == SEL_CALL);
    assign is_ret  = upd && bus.ctl_valid && (npc_sel_e'(bus.counter_selector) == SEL_JREG)
                     && bus.ret;

    always_comb begin
        nxt = pc_plus4;
        if (bus.ctl_valid) begin
            case (npc_sel_e'(bus.counter_selector))
                SEL_SEQ: begin
                    if (br_taken(npc_br_e'(bus.brtype), bus.zero_flag, bus.carry_flag,
                                 bus.msb)) begin
                        nxt = br_target;
                    end
                end
                SEL_JLBL: nxt = jlbl_target;
                SEL_JREG: nxt = bus.jmp_ra;
                SEL_CALL: nxt = jlbl_target;
                default:  nxt = pc_plus4;
            endcase
        end
    end

`ifdef NPC_RAS_EN
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;

    // A return on an empty stack neither pops nor reports a misprediction.
    assign ras_pop = is_ret && !ras_empty;

    npc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (is_call),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign mispredict_d = ras_pop && (ras_top != bus.jmp_ra);
`else
    localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras   = is_call ^ is_ret;
    assign ras_empty    = 1'b1;
    assign ras_full     = 1'b0;
    assign mispredict_d = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        flush_d = 1'b0;
        if (upd) begin
            pc_d    = nxt;
            flush_d = (nxt != pc_plus4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            flush_q      <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            flush_q      <= flush_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.link_addr      = pc_plus4;
    assign bus.flush          = flush_q;
    assign bus.ras_mispredict = mispredict_q;
    assign bus.ras_empty      = ras_empty;
    assign bus.ras_full       = ras_full;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit; RAS expectations follow NPC_RAS_EN.
module tb_next_pc_unit;
    import npc_pkg::*;

`ifdef NPC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    next_pc_unit_if #(.XLEN(32), .OFF_W(16), .JLBL_W(26)) bus ();

    next_pc_unit #(
        .XLEN      (32),
        .OFF_W     (16),
        .JLBL_W    (26),
        .RAS_DEPTH (4),
        .RESET_PC  (32'h100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall            = 1'b0;
        bus.ctl_valid        = 1'b0;
        bus.counter_selector = SEL_SEQ;
        bus.brtype           = BR_NEV;
        bus.ret              = 1'b0;
        bus.zero_flag        = 1'b0;
        bus.carry_flag       = 1'b0;
        bus.msb              = 1'b0;
        bus.branch_label     = '0;
        bus.jmp_label        = '0;
        bus.jmp_ra           = '0;
    endtask

    task automatic set_pc(input logic [31:0] addr);
        idle();
        bus.ctl_valid        = 1'b1;
        bus.counter_selector = SEL_JREG;
        bus.jmp_ra           = addr;
        step();
        idle();
    endtask

    task automatic do_call(input logic [25:0] lbl);
        idle();
        bus.ctl_valid        = 1'b1;
        bus.counter_selector = SEL_CALL;
        bus.jmp_label        = lbl;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus.pc !== 32'h100) begin
            $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h100); n_bad++; end
        n_cmp++; if (bus.flush !== 1'b0) begin
            $display("FAIL reset_flush: got %b want 0", bus.flush); n_bad++; end
        n_cmp++; if (bus.ras_mispredict !== 1'b0) begin
            $display("FAIL reset_misp: got %b want 0", bus.ras_mispredict); n_bad++; end
        n_cmp++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
            $display("FAIL reset_ras: got empty=%b full=%b want 1/0", bus.ras_empty,
                     bus.ras_full); n_bad++; end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (bus.pc !== 32'h100 + 32'(4 * i) || bus.flush !== 1'b0) begin
                $display("FAIL idle_seq%0d: got pc=%h flush=%b want pc=%h flush=0", i,
                         bus.pc, bus.flush, 32'h100 + 32'(4 * i)); n_bad++; end
        end
        n_cmp++; if (bus.link_addr !== 32'h110) begin
            $display("FAIL link_addr: got %h want %h", bus.link_addr, 32'h110); n_bad++; end
    endtask

    task automatic test_branch();
        logic [2:0]  br_v  [8] = '{3'd1, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
        logic [2:0]  zcm_v [8] = '{3'b100, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b111,
                                   3'b000};
        logic [31:0] exp_v [8] = '{32'h30, 32'h30, 32'h30, 32'h24, 32'h30, 32'h24, 32'h24,
                                   32'h30};
        // Backward branch by -2 words, taken then not taken.
        set_pc(32'h20);
        bus.ctl_valid = 1'b1; bus.brtype = BR_Z; bus.zero_flag = 1'b1;
        bus.branch_label = 16'hFFFE;
        step();
        n_cmp++; if (bus.pc !== 32'h1C || bus.flush !== 1'b1) begin
            $display("FAIL br_back_taken: got pc=%h flush=%b want 1c/1", bus.pc, bus.flush);
            n_bad++; end
        idle();
        step();
        n_cmp++; if (bus.flush !== 1'b0) begin
            $display("FAIL br_flush_pulse: got %b want 0", bus.flush); n_bad++; end
        set_pc(32'h20);
        bus.ctl_valid = 1'b1; bus.brtype = BR_Z; bus.zero_flag = 1'b0;
        bus.branch_label = 16'hFFFE;
        step();
        n_cmp++; if (bus.pc !== 32'h24 || bus.flush !== 1'b0) begin
            $display("FAIL br_not_taken: got pc=%h flush=%b want 24/0", bus.pc, bus.flush);
            n_bad++; end
        for (int i = 0; i < 8; i++) begin
            set_pc(32'h20);
            bus.ctl_valid = 1'b1; bus.brtype = br_v[i]; bus.branch_label = 16'd3;
            bus.zero_flag = zcm_v[i][2]; bus.carry_flag = zcm_v[i][1]; bus.msb = zcm_v[i][0];
            step();
            n_cmp++; if (bus.pc !== exp_v[i] || bus.flush !== (exp_v[i] != 32'h24)) begin
                $display("FAIL br_type%0d: got pc=%h flush=%b want pc=%h", br_v[i], bus.pc,
                         bus.flush, exp_v[i]); n_bad++; end
        end
        // Offset -1 lands on the same pc, still a redirect.
        set_pc(32'h20);
        bus.ctl_valid = 1'b1; bus.brtype = BR_ALW; bus.branch_label = 16'hFFFF;
        step();
        n_cmp++; if (bus.pc !== 32'h20 || bus.flush !== 1'b1) begin
            $display("FAIL br_self: got pc=%h flush=%b want 20/1", bus.pc, bus.flush);
            n_bad++; end
        set_pc(32'hFFFF_FFFC);
        n_cmp++; if (bus.link_addr !== 32'h0) begin
            $display("FAIL wrap_link: got %h want 0", bus.link_addr); n_bad++; end
        step();
        n_cmp++; if (bus.pc !== 32'h0 || bus.flush !== 1'b0) begin
            $display("FAIL wrap_pc: got pc=%h flush=%b want 0/0", bus.pc, bus.flush);
            n_bad++; end
    endtask

    task automatic test_jump();
        set_pc(32'h40);
        bus.ctl_valid = 1'b1; bus.counter_selector = SEL_JLBL; bus.jmp_label = 26'd22;
        step();
        n_cmp++; if (bus.pc !== 32'h58 || bus.flush !== 1'b1) begin
            $display("FAIL jlbl: got pc=%h flush=%b want 58/1", bus.pc, bus.flush); n_bad++; end
        bus.counter_selector = SEL_JREG; bus.jmp_ra = 32'd1045;
        step();
        n_cmp++; if (bus.pc !== 32'd1045 || bus.flush !== 1'b1) begin
            $display("FAIL jreg: got pc=%h flush=%b want %h/1", bus.pc, bus.flush, 32'd1045);
            n_bad++; end
        // Upper pc bits are kept from pc+4.
        set_pc(32'hF000_0040);
        bus.ctl_valid = 1'b1; bus.counter_selector = SEL_JLBL; bus.jmp_label = 26'd22;
        step();
        n_cmp++; if (bus.pc !== 32'hF000_0058) begin
            $display("FAIL jlbl_upper: got %h want %h", bus.pc, 32'hF000_0058); n_bad++; end
        idle();
    endtask

    task automatic test_ras();
        logic [31:0] ra;
        for (int i = 0; i < 5; i++) begin
            set_pc(32'h200 + 32'(16 * i));
            do_call(26'h400);
            n_cmp++; if (bus.pc !== 32'h1000 || bus.flush !== 1'b1) begin
                $display("FAIL call%0d: got pc=%h flush=%b want 1000/1", i, bus.pc, bus.flush);
                n_bad++; end
            if (i >= 3) begin
                n_cmp++; if (bus.ras_full !== RAS_ON || bus.ras_empty !== !RAS_ON) begin
                    $display("FAIL ras_full%0d: got full=%b empty=%b want %b/%b", i,
                             bus.ras_full, bus.ras_empty, RAS_ON, !RAS_ON); n_bad++; end
            end
        end
        for (int i = 4; i >= 0; i--) begin
            ra = 32'h204 + 32'(16 * i);
            bus.ctl_valid = 1'b1; bus.counter_selector = SEL_JREG; bus.ret = 1'b1;
            bus.jmp_ra = ra;
            step();
            n_cmp++; if (bus.pc !== ra || bus.ras_mispredict !== 1'b0) begin
                $display("FAIL ret%0d: got pc=%h misp=%b want %h/0", i, bus.pc,
                         bus.ras_mispredict, ra); n_bad++; end
            if (i <= 1) begin
                n_cmp++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
                    $display("FAIL ras_empty%0d: got empty=%b full=%b want 1/0", i,
                             bus.ras_empty, bus.ras_full); n_bad++; end
            end
        end
        idle();
    endtask

    task automatic test_mispredict();
        set_pc(32'h10);
        do_call(26'h400);
        bus.ctl_valid = 1'b1; bus.counter_selector = SEL_JREG; bus.ret = 1'b1;
        bus.jmp_ra = 32'h18;
        step();
        n_cmp++; if (bus.pc !== 32'h18 || bus.ras_mispredict !== RAS_ON) begin
            $display("FAIL misp: got pc=%h misp=%b want 18/%b", bus.pc, bus.ras_mispredict,
                     RAS_ON); n_bad++; end
        idle();
        step();
        n_cmp++; if (bus.pc !== 32'h1C || bus.ras_mispredict !== 1'b0 || bus.flush !== 1'b0) begin
            $display("FAIL misp_pulse: got pc=%h misp=%b flush=%b want 1c/0/0", bus.pc,
                     bus.ras_mispredict, bus.flush); n_bad++; end
    endtask

    task automatic test_stall();
        set_pc(32'h20);
        bus.stall = 1'b1; bus.ctl_valid = 1'b1; bus.brtype = BR_ALW; bus.branch_label = 16'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.pc !== 32'h20 || bus.flush !== 1'b0) begin
                $display("FAIL stall%0d: got pc=%h flush=%b want 20/0", i, bus.pc, bus.flush);
                n_bad++; end
        end
        bus.stall = 1'b0;
        step();
        n_cmp++; if (bus.pc !== 32'h30 || bus.flush !== 1'b1) begin
            $display("FAIL stall_release: got pc=%h flush=%b want 30/1", bus.pc, bus.flush);
            n_bad++; end
        do_call(26'h400);
        n_cmp++; if (bus.ras_empty !== !RAS_ON) begin
            $display("FAIL pre_rst_push: got empty=%b want %b", bus.ras_empty, !RAS_ON);
            n_bad++; end
        bus.stall = 1'b1; rst_n = 1'b0;
        step();
        n_cmp++; if (bus.pc !== 32'h100 || bus.ras_empty !== 1'b1 || bus.flush !== 1'b0) begin
            $display("FAIL rst_in_stall: got pc=%h empty=%b flush=%b want 100/1/0", bus.pc,
                     bus.ras_empty, bus.flush); n_bad++; end
        rst_n = 1'b1;
        bus.ctl_valid = 1'b1; bus.counter_selector = SEL_CALL; bus.jmp_label = 26'h400;
        step();
        n_cmp++; if (bus.pc !== 32'h100 || bus.ras_empty !== 1'b1) begin
            $display("FAIL stall_call: got pc=%h empty=%b want 100/1", bus.pc, bus.ras_empty);
            n_bad++; end
        idle();
        step();
        n_cmp++; if (bus.pc !== 32'h104) begin
            $display("FAIL post_stall: got %h want %h", bus.pc, 32'h104); n_bad++; end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_branch();
        test_jump();
        test_ras();
        test_mispredict();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
